// File: rtl/ys_poly_small_inv3.sv
// ys_poly_small_inv3 -- inverse of the poly_small mode-3 transform.
//
// Reads packed h words from a source RAM and rebuilds g with the prefix
// recurrence g[i] = g[i-1] - h[i]*INV3 (mod 2^13), with g[-1] = 0.
// The packed g words are written to a destination RAM.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      one-cycle run request, honoured only in IDLE
//   o_busy       high while a run is in progress
//   o_done       one-cycle pulse after the last write
//   o_rd_en      source RAM read enable
//   o_rd_addr    source word address
//   i_rd_data    source word, valid one cycle after o_rd_en
//   o_wr_en      destination RAM write enable
//   o_wr_addr    destination word address
//   o_wr_data    reconstructed g word (lane j = coefficient 4k+j)
//
// Build option: define YS_POLY_SMALL_INV3_PIPE_EN to insert a register
// stage between the multipliers and the subtract chain (one extra cycle
// of latency, identical written data).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for i_start
// S_READ  | one read per cycle, addresses 0..N_WORDS-1
// S_DRAIN | reads finished, waiting for the final write
// S_FIN   | o_done pulse, then back to S_IDLE

module ys_poly_small_inv3 #(
   parameter int COEF_W  = 13,
   parameter int LANES   = 4,
   parameter int N_COEF  = 509,
   parameter int N_WORDS = 128,
   parameter int AW      = 7,
   parameter int INV3    = 2731
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_rd_en,
   output logic [AW-1:0]             o_rd_addr,
   input  logic [COEF_W*LANES-1:0]   i_rd_data,
   output logic                      o_wr_en,
   output logic [AW-1:0]             o_wr_addr,
   output logic [COEF_W*LANES-1:0]   o_wr_data
);

   localparam logic [AW-1:0]     LAST_ADDR = AW'(N_WORDS - 1);
   localparam logic [COEF_W-1:0] INV3_C    = COEF_W'(INV3);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_rd_addr;
   logic [AW-1:0]   w_rd_addr_nxt;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_rd_addr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_addr <= w_rd_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rd_addr_nxt = r_rd_addr;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      o_rd_en       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt   = S_READ;
               w_rd_addr_nxt = '0;
            end
         end
         S_READ: begin
            o_busy  = 1'b1;
            o_rd_en = 1'b1;
            // Hold at the last address instead of wrapping to 0.
            if (r_rd_addr == LAST_ADDR) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_rd_addr_nxt = r_rd_addr + 1'b1;
            end
         end
         S_DRAIN: begin
            o_busy = 1'b1;
            // Works for either datapath depth: leave once the final word lands.
            if (o_wr_en && (o_wr_addr == LAST_ADDR)) begin
               w_state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_rd_addr = r_rd_addr;

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   logic                r_rd_vld;
   logic [AW-1:0]       r_rd_word;
   logic [COEF_W-1:0]   w_prod [LANES];
   logic [COEF_W-1:0]   w_t [LANES];
   logic                w_t_vld;
   logic [AW-1:0]       w_t_word;

   // Tracks which word is on i_rd_data (the RAM has one cycle of latency).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_vld  <= 1'b0;
         r_rd_word <= '0;
      end else begin
         r_rd_vld  <= o_rd_en;
         r_rd_word <= o_rd_addr;
      end
   end

   // Low 13 bits of h*INV3: both operands are COEF_W wide, so the product
   // is evaluated at COEF_W bits and the wrap comes for free.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         w_prod[j] = i_rd_data[j*COEF_W +: COEF_W] * INV3_C;
      end
   end

`ifdef YS_POLY_SMALL_INV3_PIPE_EN
   logic [COEF_W-1:0]   r_t [LANES];
   logic                r_t_vld;
   logic [AW-1:0]       r_t_word;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int j = 0; j < LANES; j++) begin
            r_t[j] <= '0;
         end
         r_t_vld  <= 1'b0;
         r_t_word <= '0;
      end else begin
         for (int j = 0; j < LANES; j++) begin
            r_t[j] <= w_prod[j];
         end
         r_t_vld  <= r_rd_vld;
         r_t_word <= r_rd_word;
      end
   end

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         w_t[j] = r_t[j];
      end
   end
   assign w_t_vld  = r_t_vld;
   assign w_t_word = r_t_word;
`else
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         w_t[j] = w_prod[j];
      end
   end
   assign w_t_vld  = r_rd_vld;
   assign w_t_word = r_rd_word;
`endif

   logic [COEF_W-1:0]         r_prev;
   logic [COEF_W-1:0]         w_acc;
   logic [COEF_W*LANES-1:0]   w_g_word;

   // Subtract chain across the lanes. Padding lanes (coefficient index
   // >= N_COEF) are forced to 0 and pass the running value straight
   // through, so they never disturb prev.
   always_comb begin
      w_acc    = r_prev;
      w_g_word = '0;
      for (int j = 0; j < LANES; j++) begin
         if ((int'(w_t_word) * LANES + j) < N_COEF) begin
            w_acc = w_acc - w_t[j];
            w_g_word[j*COEF_W +: COEF_W] = w_acc;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         r_prev    <= '0;
      end else begin
         o_wr_en <= w_t_vld;
         if (w_t_vld) begin
            o_wr_addr <= w_t_word;
            o_wr_data <= w_g_word;
            r_prev    <= w_acc;
         end else if ((r_state == S_IDLE) && i_start) begin
            r_prev <= '0;
         end
      end
   end

endmodule

// File: doc/ys_poly_small_inv3.md
Name: ys_poly_small_inv3

Overview:
- Inverse of the poly_small mode-3 transform. Mode 3 forms h[i] = 3*(g[i-1] - g[i]) for i > 0, and h[0] = -3*g[0].
- This block reads packed h words from the result RAM and reconstructs g with a running prefix recurrence: g[i] = g[i-1] - h[i]*inv3, with g[-1] = 0. All arithmetic is mod 2^13.
- It writes the packed g words back to a destination RAM. It sits beside the exe blocks under the poly_small controller.

Parameters:
- COEF_W, 13: coefficient width in bits (matches `DW_13`).
- LANES, 4: coefficients per packed word. Word width is COEF_W*LANES = 52 (matches `DW_PH`).
- N_COEF, 509: number of valid coefficients (NTRU_N).
- N_WORDS, 128: number of words, (N_COEF+LANES-1)/LANES.
- AW, 7: address width, clog2(N_WORDS).
- INV3, 2731: inverse of 3 mod 2^13 (3*2731 = 8193 ≡ 1).

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: single-cycle request to begin; honoured only in IDLE.
- busy, out, 1: high from the cycle after start is accepted until done.
- done, out, 1: one-cycle pulse after the last write.
- rd_en, out, 1: read enable to the source RAM.
- rd_addr, out, AW: source word address.
- rd_data, in, 52: source word; valid exactly 1 cycle after rd_en. Lane j occupies bits [13*j +: 13] and holds coefficient 4k+j.
- wr_en, out, 1: write enable to the destination RAM.
- wr_addr, out, AW: destination word address.
- wr_data, out, 52: reconstructed g word, same lane packing.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, prev=0, state=IDLE. Reset in any state aborts at once: no further reads or writes, and no done pulse.
- States:
  - IDLE: on start go to READ and clear prev to 0.
  - READ: issue rd_en=1 with rd_addr=0..N_WORDS-1, one per cycle with no gaps. After addr N_WORDS-1 go to DRAIN.
  - DRAIN: wait for the last write to complete.
  - FIN: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. start and rst in the same cycle: rst wins.
- Datapath, for the word k arriving on rd_data:
  - t_j = (h_j * INV3) mod 2^13; keep the low 13 bits of the product.
  - Chain: g_0 = prev - t_0, g_1 = g_0 - t_1, g_2 = g_1 - t_2, g_3 = g_2 - t_3. All wrap mod 2^13.
  - Register wr_data = {g_3, g_2, g_1, g_0}, set wr_en=1, wr_addr=k. prev <= g_3.
- Latency: read issued at cycle c, rd_data at c+1, wr_en at c+2. done is asserted the cycle after the final wr_en. Start-to-done is N_WORDS+3 cycles (131 by default).
- Boundary, padded lanes: lanes with index 4k+j >= N_COEF are written as 0 regardless of rd_data, and do not update prev. With N_COEF=509, word 127 lanes 1..3 are 0.
- Boundary, address counter: rd_addr never exceeds N_WORDS-1; there is no wrap back to 0 within a run.
- busy deasserts in the same cycle done asserts. Back-to-back runs are allowed: a start in the cycle after done is accepted.

Optional Feature:
- Macro: YS_POLY_SMALL_INV3_PIPE_EN.
- Defined: adds a register stage between the 4 multipliers and the subtract chain.
  - wr_en follows rd_en by 3 cycles.
  - Start-to-done becomes N_WORDS+4 cycles.
  - prev is still updated from the registered chain output, so the recurrence is unchanged.
- Undefined: single-stage datapath, latency as above.
- Written data is bit-identical in both builds.

Test Plan:
- All-zero h, start pulse: 128 writes, all wr_data=0. done pulses at cycle 131 after start.
- h word0 lane0=3, everything else 0: every valid g = 8191. Word 127 reads {0,0,0,8191}.
- h word0 lane0=1, everything else 0: g0..g508 = 5461 (-2731 mod 8192).
- Round trip: random g mod 8192 passed through the mode-3 reference model, then fed as h. Output matches g on all 509 coefficients and the padding lanes are 0. Repeat for 3 seeds, runs back-to-back.
- start re-asserted at cycles 10 and 50 of a run: ignored. Exactly 128 writes and one done pulse.
- rst asserted at cycle 60 of a run: next cycle has busy=0, rd_en=0, wr_en=0 and no done. A new start then produces the correct full result from word 0.
